phys_free_list: RTL

- Free list of physical register tags; sits directly upstream of the renaming map.
- Supplies one free physical destination tag per renamed instruction.
- Reclaims the previous physical mapping of a destination when the overwriting instruction commits.
- Circular FIFO with a per-tag membership vector that rejects double frees.

---
 rtl/phys_free_list.sv | 103 ++++++++++
 1 files changed

// File: rtl/phys_free_list.sv
// Free list of physical register tags: circular FIFO of free tags plus a per-tag
// membership vector used to reject double frees.
module phys_free_list #(
  parameter int unsigned ARCH_REG_WIDTH = 5,
  parameter int unsigned PHYS_REG_WIDTH = 6,
  localparam int unsigned NUM_ARCH  = 2 ** ARCH_REG_WIDTH,
  localparam int unsigned NUM_PHYS  = 2 ** PHYS_REG_WIDTH,
  localparam int unsigned FREE_REGS = NUM_PHYS - NUM_ARCH,
  localparam int unsigned CNT_W     = $clog2(FREE_REGS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_req_i,
  output logic                      alloc_ready_o,
  output logic [PHYS_REG_WIDTH-1:0] alloc_preg_o,
  input  logic                      free_valid_i,
  input  logic [PHYS_REG_WIDTH-1:0] free_preg_i,
  output logic [CNT_W-1:0]          count_o,
  output logic                      err_double_free_o,
  output logic                      err_overflow_o
);

  localparam int unsigned PTR_W = $clog2(FREE_REGS);
  localparam logic [NUM_PHYS-1:0] InListReset = {{FREE_REGS{1'b1}}, {NUM_ARCH{1'b0}}};

  logic [PHYS_REG_WIDTH-1:0] entry_q [FREE_REGS];
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [NUM_PHYS-1:0]       in_list_q, in_list_d;
  logic                      dfe_q, dfe_d;
  logic                      ovf_q, ovf_d;

  logic             alloc_fire;
  logic [CNT_W-1:0] count_after_alloc;
  logic             free_nonzero;
  logic             free_dup;
  logic             free_full;
  logic             free_accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FREE_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign alloc_ready_o = (count_q != '0) && !rst_i;
  assign alloc_preg_o  = entry_q[head_q];
  assign alloc_fire    = alloc_req_i && alloc_ready_o;

  // The full check sees the count after this cycle's allocation, so a free can
  // land in the slot an allocation vacates in the same cycle.
  assign count_after_alloc = count_q - CNT_W'(alloc_fire);
  assign free_nonzero      = free_valid_i && (free_preg_i != '0);
  assign free_dup          = free_nonzero && in_list_q[free_preg_i];
  assign free_full         = free_nonzero && !free_dup &&
                             (count_after_alloc == CNT_W'(FREE_REGS));
  assign free_accept       = free_nonzero && !free_dup && !free_full;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    in_list_d = in_list_q;
    dfe_d     = dfe_q || free_dup;
    ovf_d     = ovf_q || free_full;
    count_d   = count_after_alloc + CNT_W'(free_accept);
    if (alloc_fire) begin
      head_d                  = ptr_inc(head_q);
      in_list_d[alloc_preg_o] = 1'b0;
    end
    if (free_accept) begin
      tail_d                 = ptr_inc(tail_q);
      in_list_d[free_preg_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FREE_REGS); i++) begin
        entry_q[i] <= PHYS_REG_WIDTH'(int'(NUM_ARCH) + i);
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= CNT_W'(FREE_REGS);
      in_list_q <= InListReset;
      dfe_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (free_accept) begin
        entry_q[tail_q] <= free_preg_i;
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      in_list_q <= in_list_d;
      dfe_q     <= dfe_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count_o           = count_q;
  assign err_double_free_o = dfe_q;
  assign err_overflow_o    = ovf_q;

endmodule
